// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and decode helpers for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] MODE_B = 2'b00;
  localparam logic [1:0] MODE_H = 2'b01;
  localparam logic [1:0] MODE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_STORE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  function automatic logic [2:0] size_from_funct3(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [1:0] mode_from_funct3(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return MODE_B;
      2'b01:   return MODE_H;
      default: return MODE_W;
    endcase
  endfunction

  // Stores only take the signed encodings; loads also take BU/HU.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return ~we;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Aligns memory read data (MSB-justified for byte/half) and sign/zero-extends it.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  output logic [31:0] ext_data
);

  logic sext_s;

  assign sext_s = ~funct3[2];

  // Select byte/half/word and replicate the sign bit when signed.
  always_comb begin
    ext_data = 32'd0;
    case (funct3[1:0])
      2'b00:   ext_data = {{24{sext_s & rdata[31]}}, rdata[31:24]};
      2'b01:   ext_data = {{16{sext_s & rdata[31]}}, rdata[31:16]};
      default: ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: single outstanding request, byte-serial stores, extended loads.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [1:0]  mem_mode_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  lsu_state_t  state_r;
  logic [2:0]  f3_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [1:0]  cnt_r;

  logic        resp_valid_r;
  logic [31:0] resp_rdata_r;
  logic        resp_err_r;
  logic        mem_we_r;
  logic [31:0] mem_addr_r;
  logic [1:0]  mem_mode_r;
  logic [31:0] mem_wdata_r;

  logic        accept_s;
  logic [2:0]  req_size_s;
  logic [32:0] req_end_s;
  logic        req_err_s;
  logic [1:0]  cnt_next_s;
  logic        last_byte_s;
  logic [31:0] ext_s;

  assign accept_s    = req_valid_i & (state_r == ST_IDLE);
  assign req_size_s  = size_from_funct3(req_funct3_i);
  assign req_end_s   = {1'b0, req_addr_i} + {30'd0, req_size_s};
  assign req_err_s   = ~funct3_legal(req_we_i, req_funct3_i) | (req_end_s > 33'(MEM_BYTES));
  assign cnt_next_s  = cnt_r + 2'd1;
  assign last_byte_s = ({1'b0, cnt_r} == (size_from_funct3(f3_r) - 3'd1));

  load_extend u_load_extend (
    .rdata    (mem_rdata_i),
    .funct3   (f3_r),
    .ext_data (ext_s)
  );

  // Main sequencer: request latch, memory drive and response generation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      f3_r         <= 3'd0;
      addr_r       <= 32'd0;
      wdata_r      <= 32'd0;
      cnt_r        <= 2'd0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_err_r   <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= 32'd0;
      mem_mode_r   <= MODE_W;
      mem_wdata_r  <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          resp_valid_r <= 1'b0;
          if (accept_s) begin
            f3_r    <= req_funct3_i;
            addr_r  <= req_addr_i;
            wdata_r <= req_wdata_i;
            cnt_r   <= 2'd0;
            if (req_err_s) begin
              state_r      <= ST_RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_rdata_r <= 32'd0;
            end else if (req_we_i) begin
              state_r     <= ST_STORE;
              mem_we_r    <= 1'b1;
              mem_addr_r  <= req_addr_i;
              mem_mode_r  <= MODE_B;
              mem_wdata_r <= {24'd0, req_wdata_i[7:0]};
            end else begin
              state_r    <= ST_LOAD;
              mem_we_r   <= 1'b0;
              mem_addr_r <= req_addr_i;
              mem_mode_r <= mode_from_funct3(req_funct3_i);
            end
          end
        end
        ST_LOAD: begin
          state_r      <= ST_RESP;
          resp_valid_r <= 1'b1;
          resp_rdata_r <= ext_s;
          resp_err_r   <= 1'b0;
        end
        ST_STORE: begin
          if (last_byte_s) begin
            state_r      <= ST_RESP;
            mem_we_r     <= 1'b0;
            resp_valid_r <= 1'b1;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b0;
          end else begin
            cnt_r       <= cnt_next_s;
            mem_addr_r  <= addr_r + {30'd0, cnt_next_s};
            mem_wdata_r <= {24'd0, wdata_r[{cnt_next_s, 3'b000} +: 8]};
          end
        end
        ST_RESP: begin
          state_r      <= ST_IDLE;
          resp_valid_r <= 1'b0;
        end
        default: begin
          state_r      <= ST_IDLE;
          resp_valid_r <= 1'b0;
          mem_we_r     <= 1'b0;
        end
      endcase
    end
  end

  // Reset kills an in-flight write in the same cycle it is raised.
  assign mem_we_o     = mem_we_r & ~rst_i;
  assign req_ready_o  = (state_r == ST_IDLE) & ~rst_i;
  assign resp_valid_o = resp_valid_r;
  assign resp_rdata_o = resp_rdata_r;
  assign resp_err_o   = resp_err_r;
  assign mem_addr_o   = mem_addr_r;
  assign mem_mode_o   = mem_mode_r;
  assign mem_wdata_o  = mem_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-array data memory model.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [1:0]  mem_mode_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  logic [7:0]  mem [0:1023];
  logic [9:0]  ma;

  int total  = 0;
  int passed = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          wc;
  int          acc;
  int          rsp;

  load_store_unit #(.MEM_BYTES(1024)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_funct3_i (req_funct3_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_mode_o   (mem_mode_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  assign ma = mem_addr_o[9:0];

  always_comb begin
    case (mem_mode_o)
      2'b00:   mem_rdata_i = {mem[ma], 24'd0};
      2'b01:   mem_rdata_i = {mem[ma + 10'd1], mem[ma], 16'd0};
      default: mem_rdata_i = {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]};
    endcase
  end

  always @(posedge clk_i) begin
    if (mem_we_o && mem_addr_o < 32'd1024) mem[ma] <= mem_wdata_o[7:0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
  endtask

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int latency, output int wcount);
    int n;
    n = 0;
    @(negedge clk_i);
    while (!req_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    req_valid_i  = 1'b1;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    latency = 0;
    wcount  = 0;
    rdata   = 32'hx;
    err     = 1'bx;
    while (latency < 20) begin
      @(negedge clk_i);
      latency++;
      if (mem_we_o) wcount++;
      if (resp_valid_o) begin
        rdata = resp_rdata_o;
        err   = resp_err_o;
        break;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[4] = 8'h16; mem[5] = 8'h34; mem[6] = 8'h91; mem[7] = 8'h88;
    rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0;
    req_funct3_i = 3'd0; req_addr_i = 32'd0; req_wdata_i = 32'd0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_ready", 32'(req_ready_o), 32'd0);
    check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    check("rst_rdata", resp_rdata_o, 32'd0);
    check("rst_err", 32'(resp_err_o), 32'd0);
    check("rst_mem_we", 32'(mem_we_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_mem_mode", 32'(mem_mode_o), 32'd2);
    check("rst_mem_wdata", mem_wdata_o, 32'd0);
    rst_i = 1'b0;

    // Loads from the preloaded window.
    run_req(1'b0, 3'b010, 32'd4, 32'd0, rd, er, lat, wc);
    check("lw4_rdata", rd, 32'h88913416);
    check("lw4_err", 32'(er), 32'd0);
    check("lw4_lat", 32'(lat), 32'd2);
    check("lw4_no_we", 32'(wc), 32'd0);
    run_req(1'b0, 3'b000, 32'd6, 32'd0, rd, er, lat, wc);
    check("lb6", rd, 32'hFFFFFF91);
    run_req(1'b0, 3'b100, 32'd6, 32'd0, rd, er, lat, wc);
    check("lbu6", rd, 32'h00000091);
    run_req(1'b0, 3'b001, 32'd6, 32'd0, rd, er, lat, wc);
    check("lh6", rd, 32'hFFFF8891);
    run_req(1'b0, 3'b101, 32'd4, 32'd0, rd, er, lat, wc);
    check("lhu4", rd, 32'h00003416);

    // Word store is byte-serialised.
    run_req(1'b1, 3'b010, 32'd16, 32'hDEADBEEF, rd, er, lat, wc);
    check("sw16_lat", 32'(lat), 32'd5);
    check("sw16_writes", 32'(wc), 32'd4);
    check("sw16_rdata", rd, 32'd0);
    check("sw16_err", 32'(er), 32'd0);
    check("sw16_mem", {mem[19], mem[18], mem[17], mem[16]}, 32'hDEADBEEF);
    run_req(1'b0, 3'b010, 32'd16, 32'd0, rd, er, lat, wc);
    check("lw16", rd, 32'hDEADBEEF);
    run_req(1'b1, 3'b000, 32'd20, 32'h00000123, rd, er, lat, wc);
    check("sb20_lat", 32'(lat), 32'd2);
    check("sb20_writes", 32'(wc), 32'd1);
    check("sb20_mem", {16'd0, mem[21], mem[20]}, 32'h00000023);

    // Bounds and illegal encodings.
    run_req(1'b0, 3'b010, 32'd1022, 32'd0, rd, er, lat, wc);
    check("lw1022_err", 32'(er), 32'd1);
    check("lw1022_rdata", rd, 32'd0);
    check("lw1022_lat", 32'(lat), 32'd1);
    check("lw1022_no_we", 32'(wc), 32'd0);
    run_req(1'b0, 3'b010, 32'd1020, 32'd0, rd, er, lat, wc);
    check("lw1020_err", 32'(er), 32'd0);
    check("lw1020_lat", 32'(lat), 32'd2);
    run_req(1'b1, 3'b100, 32'd8, 32'hFFFF, rd, er, lat, wc);
    check("sh_f3_100_err", 32'(er), 32'd1);
    check("sh_f3_100_lat", 32'(lat), 32'd1);
    check("sh_f3_100_no_we", 32'(wc), 32'd0);
    check("sh_f3_100_mem", {mem[9], mem[8]}, 32'd0);

    // Reset after two bytes of a word store.
    @(negedge clk_i);
    req_we_i = 1'b1; req_funct3_i = 3'b010; req_addr_i = 32'd32;
    req_wdata_i = 32'hAABBCCDD; req_valid_i = 1'b1;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    #1 check("rst_mid_we_off", 32'(mem_we_o), 32'd0);
    @(negedge clk_i);
    check("rst_mid_ready", 32'(req_ready_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1 check("rst_mid_ready_after", 32'(req_ready_o), 32'd1);
    rsp = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      if (resp_valid_o) rsp++;
    end
    check("rst_mid_no_resp", 32'(rsp), 32'd0);
    check("rst_mid_mem", {mem[35], mem[34], mem[33], mem[32]}, 32'h0000CCDD);

    // Continuous valid: three accepts, three responses in nine cycles.
    @(negedge clk_i);
    req_we_i = 1'b0; req_funct3_i = 3'b010; req_addr_i = 32'd4; req_valid_i = 1'b1;
    acc = 0; rsp = 0;
    for (int i = 0; i < 9; i++) begin
      if (req_ready_o) acc++;
      if (resp_valid_o) begin
        rsp++;
        check("hold_rdata", resp_rdata_o, 32'h88913416);
      end
      @(negedge clk_i);
    end
    req_valid_i = 1'b0;
    check("hold_accepts", 32'(acc), 32'd3);
    check("hold_resps", 32'(rsp), 32'd3);

    repeat (3) @(negedge clk_i);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
